sfu_seq: RTL and testbench

Output-stage sequencer that drives the per-column `sfu` array. For each output pixel it does the following:
- clears the SFUs;
- reads the nine kernel-position partial sums from psum SRAM, using convolution address arithmetic;
- strobes `acc` once per word, then `relu` once;
- writes the finished `col`-wide result row to output SRAM.

It sits between the psum SRAM (upstream) and the output SRAM (downstream). The SFU datapath lives in the `sfu` instances it controls.

---
 rtl/sfu_seq.sv | 177 +++++++++++++++++
 tb/tb_sfu_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_seq.sv
// Output-stage sequencer: for each output pixel, clears the SFU array, streams the
// nine kernel-position psum words into it, applies ReLU and writes the result row.
module sfu_seq #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int in_w    = 6,
  parameter int o_w     = 4,
  parameter int k_w     = 3,
  parameter int addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  output logic                     busy,
  output logic                     done,
  output logic                     psum_rd_en,
  output logic [addr_w-1:0]        psum_rd_addr,
  input  logic [col*psum_bw-1:0]   psum_rdata,
  output logic [col*psum_bw-1:0]   sfu_in,
  output logic                     sfu_acc,
  output logic                     sfu_relu,
  output logic                     sfu_clr,
  output logic                     sfu_mode,
  input  logic [col*psum_bw-1:0]   sfu_out,
  output logic                     out_wr_en,
  output logic [addr_w-1:0]        out_wr_addr,
  output logic [col*psum_bw-1:0]   out_wdata
);

  localparam int kij_num = k_w * k_w;
  localparam int KCW  = $clog2(kij_num + 1);
  localparam int KJW  = $clog2(k_w + 1);
  localparam int OCW  = $clog2(o_w + 1);
  localparam int PIXW = $clog2(o_w * o_w + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RELU  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;

  // Running-base increments: next kernel plane, next kernel row, next output row.
  localparam logic [addr_w-1:0] PLANE_STEP = addr_w'(in_w * in_w);
  localparam logic [addr_w-1:0] KROW_STEP  = addr_w'(in_w - k_w + 1);
  localparam logic [addr_w-1:0] OROW_STEP  = addr_w'(in_w - o_w + 1);
  localparam logic [addr_w-1:0] ADDR_ONE   = addr_w'(1);

  localparam logic [KCW-1:0]  K_LAST   = KCW'(kij_num - 1);
  localparam logic [KCW-1:0]  K_ONE    = KCW'(1);
  localparam logic [KJW-1:0]  KJ_LAST  = KJW'(k_w - 1);
  localparam logic [KJW-1:0]  KJ_ONE   = KJW'(1);
  localparam logic [OCW-1:0]  OC_LAST  = OCW'(o_w - 1);
  localparam logic [OCW-1:0]  OC_ONE   = OCW'(1);
  localparam logic [PIXW-1:0] PIX_LAST = PIXW'(o_w * o_w - 1);
  localparam logic [PIXW-1:0] PIX_ONE  = PIXW'(1);

  logic [2:0]        state_q, state_d;
  logic [KCW-1:0]    kcnt_q, kcnt_d;
  logic [KJW-1:0]    kj_q, kj_d;
  logic [addr_w-1:0] kplane_q, kplane_d;
  logic [addr_w-1:0] koff_q, koff_d;
  logic [OCW-1:0]    ocol_q, ocol_d;
  logic [PIXW-1:0]   pix_q, pix_d;
  logic [addr_w-1:0] pix_base_q, pix_base_d;
  logic              acc_q, acc_d;
  logic              done_q, done_d;
  logic              mode_q, mode_d;

  always_comb begin
    state_d    = state_q;
    kcnt_d     = kcnt_q;
    kj_d       = kj_q;
    kplane_d   = kplane_q;
    koff_d     = koff_q;
    ocol_d     = ocol_q;
    pix_d      = pix_q;
    pix_base_d = pix_base_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    acc_d      = (state_q == S_READ);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          mode_d  = mode;
        end
      end
      S_CLR: state_d = S_READ;
      S_READ: begin
        if (kcnt_q == K_LAST) begin
          kcnt_d   = '0;
          kj_d     = '0;
          kplane_d = '0;
          koff_d   = '0;
          state_d  = S_DRAIN;
        end else begin
          kcnt_d   = kcnt_q + K_ONE;
          kplane_d = kplane_q + PLANE_STEP;
          if (kj_q == KJ_LAST) begin
            kj_d   = '0;
            koff_d = koff_q + KROW_STEP;
          end else begin
            kj_d   = kj_q + KJ_ONE;
            koff_d = koff_q + ADDR_ONE;
          end
        end
      end
      S_DRAIN: state_d = S_RELU;
      S_RELU:  state_d = S_WRITE;
      S_WRITE: begin
        if (pix_q == PIX_LAST) begin
          pix_d      = '0;
          ocol_d     = '0;
          pix_base_d = '0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          pix_d   = pix_q + PIX_ONE;
          state_d = S_CLR;
          if (ocol_q == OC_LAST) begin
            ocol_d     = '0;
            pix_base_d = pix_base_q + OROW_STEP;
          end else begin
            ocol_d     = ocol_q + OC_ONE;
            pix_base_d = pix_base_q + ADDR_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kcnt_q     <= '0;
      kj_q       <= '0;
      kplane_q   <= '0;
      koff_q     <= '0;
      ocol_q     <= '0;
      pix_q      <= '0;
      pix_base_q <= '0;
      acc_q      <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kcnt_q     <= kcnt_d;
      kj_q       <= kj_d;
      kplane_q   <= kplane_d;
      koff_q     <= koff_d;
      ocol_q     <= ocol_d;
      pix_q      <= pix_d;
      pix_base_q <= pix_base_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      mode_q     <= mode_d;
    end
  end

  // acc trails the read strobe by the fixed one-cycle SRAM latency.
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign psum_rd_en   = (state_q == S_READ);
  assign psum_rd_addr = psum_rd_en ? (kplane_q + koff_q + pix_base_q) : '0;
  assign sfu_in       = psum_rdata;
  assign sfu_acc      = acc_q;
  assign sfu_relu     = (state_q == S_RELU);
  assign sfu_clr      = (state_q == S_CLR);
  assign sfu_mode     = mode_q;
  assign out_wr_en    = (state_q == S_WRITE);
  assign out_wr_addr  = addr_w'(pix_q);
  assign out_wdata    = sfu_out;

endmodule

// File: tb/tb_sfu_seq.sv
// Scoreboard bench for sfu_seq: behavioural psum SRAM and SFU array around the DUT,
// expected reads/writes queued at frame start and matched as the DUT produces them.
module tb_sfu_seq;

  localparam int COL  = 8;
  localparam int PBW  = 16;
  localparam int IN_W = 6;
  localparam int O_W  = 4;
  localparam int K_W  = 3;
  localparam int AW   = 11;

  logic                 clk = 1'b0;
  logic                 reset, start, mode;
  logic                 busy, done, psum_rd_en;
  logic [AW-1:0]        psum_rd_addr, out_wr_addr;
  logic [COL*PBW-1:0]   psum_rdata, sfu_in, sfu_out, out_wdata;
  logic                 sfu_acc, sfu_relu, sfu_clr, sfu_mode, out_wr_en;

  sfu_seq #(.col(COL), .psum_bw(PBW), .in_w(IN_W), .o_w(O_W), .k_w(K_W), .addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .psum_rdata(psum_rdata),
    .sfu_in(sfu_in), .sfu_acc(sfu_acc), .sfu_relu(sfu_relu), .sfu_clr(sfu_clr),
    .sfu_mode(sfu_mode), .sfu_out(sfu_out),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wdata(out_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               addr;
    int               cyc;
    logic [COL*PBW-1:0] data;
  } ev_t;

  ev_t  rq[$];
  ev_t  wq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   st = 0;
  int   cur_pat = 0;
  int   wr_cnt = 0;
  bit   frame_on = 1'b0;
  logic frame_mode = 1'b0;
  logic rd_prev = 1'b0;
  logic rst_prev = 1'b1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Column words as a function of address; pattern 1 puts -3 on pixel-0 addresses in column 0.
  function automatic logic [COL*PBW-1:0] mem_word(input int a, input int pat);
    logic [COL*PBW-1:0] w;
    int r, k;
    w = '0;
    r = a % (IN_W * IN_W);
    k = a / (IN_W * IN_W);
    for (int c = 0; c < COL; c++) begin
      case (pat)
        0: w[c*PBW +: PBW] = 16'(a);
        1: begin
          if (c == 0) w[c*PBW +: PBW] = (r == (k / K_W) * IN_W + k % K_W) ? -16'sd3 : 16'sd2;
          else        w[c*PBW +: PBW] = 16'((a % 7) - 3);
        end
        default: w[c*PBW +: PBW] = 16'h05FC;
      endcase
    end
    return w;
  endfunction

  function automatic int rd_addr(input int p, input int k);
    int orow, ocol, ki, kj;
    orow = p / O_W;  ocol = p % O_W;
    ki = k / K_W;    kj = k % K_W;
    return k * IN_W * IN_W + (orow + ki) * IN_W + (ocol + kj);
  endfunction

  function automatic logic [COL*PBW-1:0] exp_pix(input int p, input int pat, input logic m);
    logic [COL*PBW-1:0] w, r;
    logic signed [15:0] t16;
    logic signed [7:0]  th, tl;
    int s, sh, sl;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      s = 0; sh = 0; sl = 0;
      for (int k = 0; k < K_W * K_W; k++) begin
        w   = mem_word(rd_addr(p, k), pat);
        t16 = w[c*PBW +: 16];
        th  = w[c*PBW + 8 +: 8];
        tl  = w[c*PBW +: 8];
        s  += int'(t16);
        sh += int'(th);
        sl += int'(tl);
      end
      if (m) begin
        r[c*PBW + 8 +: 8] = (sh < 0) ? 8'd0 : 8'(sh);
        r[c*PBW +: 8]     = (sl < 0) ? 8'd0 : 8'(sl);
      end else begin
        r[c*PBW +: 16] = (s < 0) ? 16'd0 : 16'(s);
      end
    end
    return r;
  endfunction

  always @(posedge clk) if (psum_rd_en) psum_rdata <= mem_word(int'(psum_rd_addr), cur_pat);

  // SFU array: per-column accumulator, 16-bit or two 8-bit lanes, with ReLU.
  logic [15:0] sacc [COL];
  always @(posedge clk) begin
    for (int c = 0; c < COL; c++) begin
      if (reset || sfu_clr) sacc[c] <= '0;
      else if (sfu_acc) begin
        if (sfu_mode) sacc[c] <= {sacc[c][15:8] + sfu_in[c*PBW + 8 +: 8], sacc[c][7:0] + sfu_in[c*PBW +: 8]};
        else          sacc[c] <= sacc[c] + sfu_in[c*PBW +: 16];
      end else if (sfu_relu) begin
        if (sfu_mode) sacc[c] <= {sacc[c][15] ? 8'd0 : sacc[c][15:8], sacc[c][7] ? 8'd0 : sacc[c][7:0]};
        else          sacc[c] <= sacc[c][15] ? 16'd0 : sacc[c];
      end
    end
  end

  always_comb begin
    sfu_out = '0;
    for (int c = 0; c < COL; c++) sfu_out[c*PBW +: PBW] = sacc[c];
  end

  ev_t mon_e;
  int  mon_rel;
  always @(negedge clk) begin
    if (psum_rd_en) begin
      if (rq.size() > 0) begin
        mon_e = rq.pop_front();
        chk("rd_addr", psum_rd_addr, mon_e.addr);
        chk("rd_cyc", cyc, mon_e.cyc);
      end else chk("rd_unexpected", 1, 0);
    end
    if (out_wr_en) begin
      wr_cnt++;
      if (wq.size() > 0) begin
        mon_e = wq.pop_front();
        chk("wr_addr", out_wr_addr, mon_e.addr);
        chk("wr_data", out_wdata, mon_e.data);
        chk("wr_cyc", cyc, mon_e.cyc);
      end else chk("wr_unexpected", 1, 0);
    end
    if (!reset && !rst_prev) chk("acc_delay", sfu_acc, rd_prev);
    rd_prev  = psum_rd_en;
    rst_prev = reset;
    if (frame_on) begin
      mon_rel = cyc - st;
      chk("busy", busy, (mon_rel >= 1 && mon_rel <= 208));
      if (busy) chk("sfu_mode", sfu_mode, frame_mode);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic m, input int pat);
    tick();
    cur_pat    = pat;
    start      = 1'b1;
    mode       = m;
    st         = cyc;
    frame_mode = m;
    for (int p = 0; p < O_W * O_W; p++) begin
      for (int k = 0; k < K_W * K_W; k++)
        rq.push_back('{addr: rd_addr(p, k), cyc: st + 13 * p + 2 + k, data: '0});
      wq.push_back('{addr: p, cyc: st + 13 * (p + 1), data: exp_pix(p, pat, m)});
    end
    frame_on = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (done) got = 1'b1;
      else tick();
    end
    if (got) chk("done_cyc", cyc - st, 209);
    else     chk("done_timeout", 0, 1);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    frame_on = 1'b0;
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
  endtask

  initial begin
    int w0;
    reset = 1'b1;
    start = 1'b1;
    mode  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", psum_rd_en, 0);
      chk("rst_acc", sfu_acc, 0);
      chk("rst_relu", sfu_relu, 0);
      chk("rst_clr", sfu_clr, 0);
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_mode", sfu_mode, 0);
      chk("rst_rd_addr", psum_rd_addr, 0);
      chk("rst_wr_addr", out_wr_addr, 0);
      chk("rst_wdata", out_wdata, sfu_out);
    end
    #1;
    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    repeat (3) tick();

    // Address frame, with a start pulse while busy that must be ignored.
    start_frame(1'b0, 0);
    repeat (29) tick();
    start = 1'b1;
    mode  = 1'b1;
    tick();
    start = 1'b0;
    mode  = 1'b0;
    wait_done();

    start_frame(1'b0, 1);
    wait_done();

    // SIMD frame with the mode input toggled mid-frame.
    start_frame(1'b1, 2);
    repeat (38) tick();
    mode = 1'b0;
    repeat (60) tick();
    mode = 1'b1;
    wait_done();
    mode = 1'b0;

    // Reset in cycle 50 abandons the frame.
    start_frame(1'b0, 0);
    repeat (49) tick();
    reset    = 1'b1;
    frame_on = 1'b0;
    rq.delete();
    wq.delete();
    w0 = wr_cnt;
    tick();
    chk("busy_after_rst", busy, 0);
    chk("wr_en_after_rst", out_wr_en, 0);
    chk("mode_after_rst", sfu_mode, 0);
    reset = 1'b0;
    repeat (40) tick();
    chk("no_wr_after_rst", wr_cnt - w0, 0);

    start_frame(1'b0, 0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
